// File: rtl/chan_arb_mux_pkg.sv
// Shared definitions for the channel arbiter/selector: arbitration modes,
// FSM state encoding and the grant-index width helper.
package chan_arb_mux_pkg;

    localparam logic MODE_PRIO = 1'b0;
    localparam logic MODE_RR   = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    // Grant index width, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chan_arb_mux_if.sv
// Source-side request/data bundle plus the downstream valid/ready word port.
// master = sources and sink, slave = the arbiter.
interface chan_arb_mux_if #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 8
);
    import chan_arb_mux_pkg::*;
    localparam int IDX_W = idx_w(N_CH);

    logic                     mode;
    logic [N_CH-1:0]          req;
    logic [N_CH*DATA_W-1:0]   data_in;
    logic [N_CH-1:0]          ack;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_W-1:0]        out_data;
    logic [IDX_W-1:0]         grant_idx;

    modport master (
        output mode, req, data_in, out_ready,
        input  ack, out_valid, out_data, grant_idx
    );

    modport slave (
        input  mode, req, data_in, out_ready,
        output ack, out_valid, out_data, grant_idx
    );

endinterface

// File: rtl/chan_arb_mux_rr_pick.sv
// Combinational winner search: rotate req so rr_ptr lands at bit 0, take the
// lowest set bit, then add the pointer back modulo N_CH. Priority mode uses a zero rotation.
module chan_arb_mux_rr_pick
    import chan_arb_mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int IDX_W = idx_w(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [IDX_W-1:0] rr_ptr,
    input  logic             mode,
    output logic [IDX_W-1:0] winner,
    output logic             found
);

    localparam logic [IDX_W:0] N_VAL = (IDX_W+1)'(N_CH);

    logic [IDX_W-1:0]  base;
    logic [2*N_CH-1:0] dbl;
    logic [N_CH-1:0]   rot;
    logic [IDX_W-1:0]  off;
    logic [IDX_W:0]    sum;

    always_comb begin
        base  = (mode == MODE_RR) ? rr_ptr : '0;
        dbl   = {req, req} >> base;
        rot   = dbl[N_CH-1:0];
        found = |req;
        off   = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (rot[i]) off = IDX_W'(i);
        end
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= N_VAL) sum = sum - N_VAL;
        winner = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/chan_arb_mux.sv
// N-channel registered selector: arbitrates requests (fixed priority or round-robin),
// latency 1 cycle req->out_valid; under out_ready=0 the held word is kept and no channel is acked.
module chan_arb_mux
    import chan_arb_mux_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int DATA_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    chan_arb_mux_if.slave bus
);

    localparam int IDX_W = idx_w(N_CH);

    state_t            state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  winner;
    logic              found;
    logic              cap;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [IDX_W-1:0]  grant_q;
    logic [N_CH-1:0]   ack_c;

    chan_arb_mux_rr_pick #(
        .N_CH  (N_CH),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (bus.req),
        .rr_ptr (rr_ptr),
        .mode   (bus.mode),
        .winner (winner),
        .found  (found)
    );

    // A held word may be replaced in the same edge it is accepted downstream.
    assign cap = found && ((state == ST_IDLE) || ((state == ST_FULL) && bus.out_ready));

    always_comb begin
        ack_c = '0;
        if (cap && rst_n) ack_c[winner] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            grant_q     <= '0;
        end else begin
            case (state)
                ST_IDLE: if (cap) state <= ST_FULL;
                ST_FULL: if (bus.out_ready && !found) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase

            if (cap) begin
                out_data_q  <= bus.data_in[winner*DATA_W +: DATA_W];
                grant_q     <= winner;
                out_valid_q <= 1'b1;
                if (bus.mode == MODE_RR) begin
                    rr_ptr <= (winner == IDX_W'(N_CH - 1)) ? '0 : winner + IDX_W'(1);
                end
            end else if ((state == ST_FULL) && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.ack       = ack_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.grant_idx = grant_q;

endmodule

// File: tb/tb_chan_arb_mux.sv
// Randomised and directed checks of chan_arb_mux against a queue-free behavioural
// model: winner found by an explicit modular scan, word register tracked per cycle.
module tb_chan_arb_mux;

    localparam int N = 4;
    localparam int W = 8;

    logic clk;
    logic rst_n;

    chan_arb_mux_if #(.N_CH(N), .DATA_W(W)) bus ();

    chan_arb_mux #(.N_CH(N), .DATA_W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    logic [W-1:0] ch_dat [N];

    bit           m_full;
    int           m_ptr;
    logic [W-1:0] m_dat;
    int           m_gnt;
    bit           m_vld;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic md, input logic [N-1:0] r, input logic rdy);
        bus.mode      = md;
        bus.req       = r;
        bus.out_ready = rdy;
        for (int k = 0; k < N; k++) bus.data_in[k*W +: W] = ch_dat[k];
    endtask

    function automatic int pick(input logic [N-1:0] r, input logic md, input int ptr);
        int start;
        start = md ? ptr : 0;
        for (int k = 0; k < N; k++) begin
            if (r[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_full = 0; m_ptr = 0; m_dat = '0; m_gnt = 0; m_vld = 0;
    endtask

    task automatic check_outs(input string pfx);
        chk({pfx, "_vld"}, 32'(bus.out_valid), 32'(m_vld));
        chk({pfx, "_dat"}, 32'(bus.out_data), 32'(m_dat));
        chk({pfx, "_gnt"}, 32'(bus.grant_idx), 32'(m_gnt));
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic cycle(input string pfx);
        int         w;
        bit         cap;
        logic [N-1:0] ea;
        w   = pick(bus.req, bus.mode, m_ptr);
        cap = (w >= 0) && (!m_full || bus.out_ready);
        ea  = cap ? (N'(1) << w) : '0;
        #1;
        chk({pfx, "_ack"}, 32'(bus.ack), 32'(ea));
        @(posedge clk);
        if (cap) begin
            m_dat  = ch_dat[w];
            m_gnt  = w;
            m_vld  = 1;
            m_full = 1;
            if (bus.mode) m_ptr = (w + 1) % N;
        end else if (m_full && bus.out_ready) begin
            m_vld  = 0;
            m_full = 0;
        end
        #1;
        check_outs(pfx);
        @(negedge clk);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int k = 0; k < N; k++) ch_dat[k] = W'(8'hE0 + k);
        model_reset();

        // Reset held with every channel requesting.
        rst_n = 1'b0;
        drive(1'b0, 4'b1111, 1'b1);
        #3;
        check_outs("rst");
        chk("rst_ack", 32'(bus.ack), 32'h0);
        @(negedge clk);
        chk("rst_ack2", 32'(bus.ack), 32'h0);
        rst_n = 1'b1;
        cycle("rel");

        // Fixed priority: channel 3 starved by channel 1.
        ch_dat[1] = 8'h11; ch_dat[3] = 8'h33;
        drive(1'b0, 4'b1010, 1'b1);
        repeat (4) cycle("prio");

        // Round-robin sweep with wrap.
        for (int k = 0; k < N; k++) ch_dat[k] = W'(8'hA0 + k);
        drive(1'b1, 4'b1111, 1'b1);
        repeat (5) cycle("rr");

        // Backpressure: hold 8'h22 while inputs churn.
        ch_dat[2] = 8'h22;
        drive(1'b0, 4'b0100, 1'b1);
        cycle("bp_ld");
        for (int c = 0; c < 5; c++) begin
            for (int k = 0; k < N; k++) ch_dat[k] = W'($urandom);
            drive(1'($urandom), N'($urandom), 1'b0);
            cycle("bp_hold");
        end
        ch_dat[2] = 8'h4D;
        drive(1'b0, 4'b0100, 1'b1);
        cycle("bp_rel");

        // Drain to idle after a single pulse on channel 3.
        ch_dat[3] = 8'h5C;
        drive(1'b0, 4'b1000, 1'b1);
        cycle("drn_cap");
        drive(1'b0, 4'b0000, 1'b1);
        repeat (2) cycle("drn_idle");

        // Move the rr pointer, then reset asynchronously while a word is held.
        drive(1'b1, 4'b0010, 1'b1);
        cycle("pre_ar");
        drive(1'b1, 4'b1111, 1'b0);
        cycle("pre_ar_hold");
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outs("arst");
        chk("arst_ack", 32'(bus.ack), 32'h0);
        #1 rst_n = 1'b1;
        for (int k = 0; k < N; k++) ch_dat[k] = W'(8'hC0 + k);
        drive(1'b1, 4'b1111, 1'b0);
        cycle("post_ar");

        // Random traffic with occasional mode flips.
        begin
            logic md;
            md = 1'b1;
            for (int c = 0; c < 400; c++) begin
                logic [N-1:0] r;
                if ($urandom_range(0, 15) == 0) md = ~md;
                for (int k = 0; k < N; k++) ch_dat[k] = W'($urandom);
                r = ($urandom_range(0, 5) == 0) ? N'(1 << $urandom_range(0, N-1)) : N'($urandom);
                drive(md, r, ($urandom_range(0, 9) < 7));
                cycle("rand");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/chan_arb_mux.md
Name: chan_arb_mux

Overview:
- Parametrised N-channel, W-bit registered selector. Successor to the 2-channel combinational data selector.
- Each source presents data with a request. The block arbitrates among the sources, registers the winner's data and presents it downstream with a valid/ready handshake.
- Sits between the display/time-field sources and the display-formatting stage.
- Supports fixed-priority and round-robin arbitration, selectable at run time.

Parameters:
- N_CH, 4, number of input channels (2..16).
- DATA_W, 8, width of each channel's data.
- IDX_W, $clog2(N_CH) with a minimum of 1, width of the grant index (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  1  0 = fixed priority (lowest index wins); 1 = round-robin.
- req  in  N_CH  per-channel request, level.
- data_in  in  N_CH*DATA_W  packed channel data; channel k occupies bits [k*DATA_W +: DATA_W].
- ack  out  N_CH  one-cycle pulse to the captured channel.
- out_valid  out  1  out_data holds a captured word.
- out_ready  in  1  downstream accepts the word.
- out_data  out  DATA_W  registered selected data.
- grant_idx  out  IDX_W  index of the channel held in out_data.

Behaviour:
- Reset (asynchronous, rst_n low):
  - out_valid=0, out_data=0, grant_idx=0, ack=0.
  - Round-robin pointer rr_ptr=0.
  - FSM state = IDLE.
- Capture condition: cap = |req && (state==IDLE || (state==FULL && out_ready)).
- On cap, at the clock edge:
  - out_data <= data_in of the winner, grant_idx <= winner, out_valid <= 1.
  - ack[winner] is 1 for exactly that cycle; it is combinational with cap and the winner, valid in the cycle the data is sampled.
  - The source treats ack as "word consumed" and may change its data or drop req on the next cycle.
- Winner selection:
  - mode=0: lowest-index channel with req set.
  - mode=1: first channel with req set, scanning upward from rr_ptr and wrapping from N_CH-1 to 0.
  - After a capture in mode 1: rr_ptr <= winner+1, wrapping to 0 when winner==N_CH-1.
  - In mode 0, rr_ptr is unchanged.
- FSM:
  - IDLE: out_valid=0. On cap, go to FULL.
  - FULL: out_valid=1 and out_data is stable.
    - out_ready=1 and |req: capture the new winner in the same edge and stay in FULL. This gives a back-to-back throughput of 1 word/cycle.
    - out_ready=1 and no req: go to IDLE; out_valid falls next cycle.
    - out_ready=0: hold everything, ack=0.
- Boundaries:
  - A req that drops while the block is in FULL with out_ready=0 is never acked.
  - No req: no ack, state unchanged.
  - A mode change takes effect at the next arbitration. rr_ptr is retained across mode changes.
  - A single requester is granted every eligible cycle in both modes.
  - Reset asserted mid-transfer:
    - The captured word is discarded and out_valid drops immediately (asynchronously).
    - ack is forced to 0 while rst_n is low.
- Latency: req to out_valid is 1 cycle.
- No combinational path from out_ready to out_data. out_ready reaches ack only through cap.

Decomposition:
- Package/include (chan_arb_defs): MODE_PRIO=1'b0, MODE_RR=1'b1, state encodings ST_IDLE/ST_FULL.
- Sub-module rr_pick: combinational, parametrised by N_CH.
  - Inputs: req, rr_ptr, mode.
  - Outputs: winner index and a found flag.
  - Implement it by rotating req by rr_ptr, finding the lowest set bit, then un-rotating; for mode 0 use a rotation of 0.
- The top level holds the FSM, rr_ptr, output registers and the ack decode.

Test Plan:
- Reset: hold rst_n=0 with req=4'b1111 -> out_valid=0, out_data=8'h00, ack=0. Release rst_n -> next edge captures channel 0, out_valid=1.
- Priority: mode=0, req=4'b1010, data_in ch1=8'h11, ch3=8'h33, out_ready=1 continuously -> every cycle grant_idx=1, out_data=8'h11, ack=4'b0010; channel 3 is starved.
- Round-robin: mode=1, req=4'b1111, channel data 8'hA0..A3, out_ready=1 -> grant_idx sequence 0,1,2,3,0, ack rotating one-hot, rr_ptr wraps from 3 to 0.
- Backpressure: in FULL with out_data=8'h22, set out_ready=0 for 5 cycles while changing data_in and req -> out_data stays 8'h22, ack=0 throughout. Raise out_ready with req=4'b0100 -> same edge captures ch2, ack=4'b0100.
- Drain to idle: single req pulse on ch3 (8'h5C), then no req, out_ready=1 -> out_valid high for exactly 1 cycle, then IDLE with out_valid=0.
- Async reset mid-transfer: FULL with out_ready=0, pulse rst_n low between clock edges -> out_valid and out_data clear immediately. After release, rr_ptr=0, so with mode=1 and req=4'b1111 the first grant is ch0.
